// File: rtl/trig_timestamp_unpacker.sv
// trig_timestamp_unpacker: pairs low/high 32-bit FIFO words into 64-bit trigger
// timestamps and presents them with an index (and optionally a delta) on a
// valid/ready interface. Flags orphaned low words and non-monotonic timestamps.
// Optional macro TRIG_TS_DELTA_EN: enables delta computation and order_err;
// when undefined, ts_delta and order_err are tied to 0.
module trig_timestamp_unpacker #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned INDEX_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  output logic                   data_word_rd_en,
  input  logic [31:0]            data_word,
  input  logic                   data_buf_empty,
  input  logic                   clear,
  output logic                   ts_valid,
  input  logic                   ts_ready,
  output logic [63:0]            ts_value,
  output logic [31:0]            ts_delta,
  output logic [INDEX_WIDTH-1:0] ts_index,
  output logic                   orphan_err,
  output logic                   order_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO_CAP,
    S_HI_REQ,
    S_HI_CAP,
    S_OUT
  } state_t;

  state_t                 state, state_nxt;
  logic [31:0]            lo_q;
  logic [CNT_W-1:0]       tmo_cnt;
  logic [INDEX_WIDTH-1:0] idx_cnt;
  logic [INDEX_WIDTH-1:0] idx_base;
  logic [63:0]            ts_full;
  logic                   timeout_hit;

  assign ts_full  = {data_word, lo_q};
  // A clear coinciding with S_HI_CAP makes this record the first one.
  assign idx_base = clear ? '0 : idx_cnt;

  // Next-state logic and the combinational FIFO read strobe.
  always_comb begin
    state_nxt       = state;
    data_word_rd_en = 1'b0;
    timeout_hit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!data_buf_empty) begin
          data_word_rd_en = 1'b1;
          state_nxt       = S_LO_CAP;
        end
      end
      S_LO_CAP: state_nxt = S_HI_REQ;
      S_HI_REQ: begin
        if (!data_buf_empty) begin
          data_word_rd_en = 1'b1;
          state_nxt       = S_HI_CAP;
        end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      S_HI_CAP: state_nxt = S_OUT;
      S_OUT: begin
        if (ts_ready) begin
          if (!data_buf_empty) begin
            data_word_rd_en = 1'b1;
            state_nxt       = S_LO_CAP;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Pairing datapath, output record, index counter and orphan flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lo_q       <= '0;
      tmo_cnt    <= '0;
      idx_cnt    <= '0;
      ts_valid   <= 1'b0;
      ts_value   <= '0;
      ts_index   <= '0;
      orphan_err <= 1'b0;
    end else begin
      case (state)
        S_LO_CAP: begin
          lo_q    <= data_word;
          tmo_cnt <= '0;
        end
        S_HI_REQ: begin
          if (timeout_hit)          lo_q    <= '0;
          else if (data_buf_empty)  tmo_cnt <= tmo_cnt + 1'b1;
        end
        S_HI_CAP: begin
          ts_value <= ts_full;
          ts_index <= idx_base;
          ts_valid <= 1'b1;
        end
        S_OUT: begin
          if (ts_ready) ts_valid <= 1'b0;
        end
        default: ;
      endcase
      if (state == S_HI_CAP) idx_cnt <= idx_base + 1'b1;
      else if (clear)        idx_cnt <= '0;
      if (timeout_hit)       orphan_err <= 1'b1;
      else if (clear)        orphan_err <= 1'b0;
    end
  end

`ifdef TRIG_TS_DELTA_EN
  logic [63:0] prev_ts;
  logic        prev_valid;
  logic        prev_eff;
  logic [63:0] diff;
  logic        order_viol;
  logic [31:0] delta_calc;

  // Delta against the previous timestamp, saturating, zero on first or out-of-order.
  always_comb begin
    prev_eff   = prev_valid && !clear;
    diff       = ts_full - prev_ts;
    order_viol = prev_eff && (ts_full < prev_ts);
    delta_calc = '0;
    if (prev_eff && !order_viol) begin
      delta_calc = (diff[63:32] != '0) ? '1 : diff[31:0];
    end
  end

  // Previous-timestamp tracking, registered delta and sticky order error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_ts    <= '0;
      prev_valid <= 1'b0;
      ts_delta   <= '0;
      order_err  <= 1'b0;
    end else begin
      if (state == S_HI_CAP) begin
        prev_ts    <= ts_full;
        prev_valid <= 1'b1;
        ts_delta   <= delta_calc;
      end else if (clear) begin
        prev_ts    <= '0;
        prev_valid <= 1'b0;
      end
      if ((state == S_HI_CAP) && order_viol) order_err <= 1'b1;
      else if (clear)                        order_err <= 1'b0;
    end
  end
`else
  assign ts_delta  = '0;
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_trig_timestamp_unpacker.sv
// Directed bench for trig_timestamp_unpacker with a FIFO model and a record scoreboard.
module tb_trig_timestamp_unpacker;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          data_word_rd_en;
  logic [31:0]   data_word = '0;
  logic          data_buf_empty = 1'b1;
  logic          clear = 1'b0;
  logic          ts_valid;
  logic          ts_ready = 1'b0;
  logic [63:0]   ts_value;
  logic [31:0]   ts_delta;
  logic [IW-1:0] ts_index;
  logic          orphan_err;
  logic          order_err;

  trig_timestamp_unpacker #(.TIMEOUT_CYCLES(16), .INDEX_WIDTH(IW)) dut (
    .clk(clk), .resetn(resetn), .data_word_rd_en(data_word_rd_en),
    .data_word(data_word), .data_buf_empty(data_buf_empty), .clear(clear),
    .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_value(ts_value),
    .ts_delta(ts_delta), .ts_index(ts_index), .orphan_err(orphan_err),
    .order_err(order_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]   v;
    logic [31:0]   d;
    logic [IW-1:0] i;
  } rec_t;

  rec_t        sb[$];
  logic [31:0] fifo[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_acc = -1;
  bit          spacing_chk = 0;
  bit          hold_mode = 0;

  // reference model state
  logic [63:0]   m_prev = '0;
  bit            m_pv = 0;
  logic [IW-1:0] m_idx = '0;
  bit            m_order = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_prev = '0; m_pv = 0; m_idx = '0; m_order = 0;
  endtask

  function automatic logic [31:0] model_delta(input logic [63:0] ts);
    logic [31:0] d;
    logic [63:0] diff;
    d = '0;
`ifdef TRIG_TS_DELTA_EN
    if (m_pv) begin
      if (ts < m_prev) begin
        m_order = 1;
      end else begin
        diff = ts - m_prev;
        d = (diff[63:32] != 0) ? 32'hFFFF_FFFF : diff[31:0];
      end
    end
`endif
    m_prev = ts;
    m_pv = 1;
    return d;
  endfunction

  task automatic push_word(input logic [31:0] w);
    fifo.push_back(w);
    data_buf_empty = 1'b0;
  endtask

  task automatic push_pair(input logic [31:0] lo, input logic [31:0] hi);
    rec_t r;
    push_word(lo);
    push_word(hi);
    r.v = {hi, lo};
    r.d = model_delta({hi, lo});
    r.i = m_idx;
    m_idx = m_idx + 1'b1;
    sb.push_back(r);
  endtask

  // One clock: checks before the edge, FIFO read data update 1ns after it.
  task automatic step();
    logic rd;
    @(negedge clk);
    if (data_word_rd_en) chk("rd_en_while_empty", data_buf_empty, 0);
    if (hold_mode) chk("rd_en_during_hold", data_word_rd_en, 0);
    if (ts_valid) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_record observed=%h expected=none", ts_value);
      end
      if (sb.size() != 0) begin
        chk("ts_value", ts_value, sb[0].v);
        chk("ts_delta", ts_delta, sb[0].d);
        chk("ts_index", ts_index, sb[0].i);
        if (ts_ready) begin
          void'(sb.pop_front());
          if (spacing_chk && last_acc >= 0) chk("accept_spacing", cyc - last_acc, 4);
          last_acc = cyc;
        end
      end
    end
    rd = data_word_rd_en;
    @(posedge clk);
    #1;
    cyc++;
    if (rd && fifo.size() != 0) data_word = fifo.pop_front();
    data_buf_empty = (fifo.size() == 0);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || ts_valid) && n < 200) begin
      step();
      n++;
    end
    chk("drain_within_budget", n < 200, 1);
    steps(2);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_clear();
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_ts_valid", ts_valid, 0);
    chk("rst_rd_en", data_word_rd_en, 0);
    chk("rst_ts_value", ts_value, 0);
    chk("rst_ts_index", ts_index, 0);
    chk("rst_orphan", orphan_err, 0);
    chk("rst_order", order_err, 0);
    steps(2);
    resetn = 1'b1;
    steps(2);

    // basic records and delta
    ts_ready = 1'b1;
    push_pair(32'h10, 32'h0);
    drain();
    push_pair(32'h110, 32'h0);
    drain();

    // saturated delta
    push_pair(32'h0, 32'h1);
    push_pair(32'h5, 32'h3);
    drain();
    chk("order_after_sat", order_err, m_order);

    // non-monotonic timestamp, then clear
    push_pair(32'h200, 32'h0);
    push_pair(32'h100, 32'h0);
    drain();
    chk("order_set", order_err, m_order);
    steps(5);
    chk("order_sticky", order_err, m_order);
    do_clear();
    step();
    chk("order_cleared", order_err, 0);
    push_pair(32'h300, 32'h0);
    drain();

    // orphaned low word, then realignment
    push_word(32'h777);
    steps(30);
    chk("orphan_set", orphan_err, 1);
    chk("orphan_no_valid", ts_valid, 0);
    push_pair(32'h5, 32'h0);
    drain();
    chk("orphan_sticky", orphan_err, 1);
    chk("order_after_orphan", order_err, m_order);
    do_clear();
    step();
    chk("orphan_cleared", orphan_err, 0);

    // backpressure hold, then back-to-back records
    ts_ready = 1'b0;
    push_pair(32'h1000, 32'h0);
    push_pair(32'h1010, 32'h0);
    push_pair(32'h1030, 32'h0);
    begin
      int n;
      n = 0;
      while (!ts_valid && n < 50) begin step(); n++; end
      chk("first_valid_seen", ts_valid, 1);
    end
    hold_mode = 1;
    steps(10);
    hold_mode = 0;
    chk("hold_index", ts_index, 0);
    ts_ready = 1'b1;
    spacing_chk = 1;
    last_acc = -1;
    drain();
    spacing_chk = 0;

    // asynchronous reset in the middle of a pair
    push_word(32'hABC);
    steps(3);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_ts_valid", ts_valid, 0);
    chk("arst_ts_value", ts_value, 0);
    chk("arst_ts_delta", ts_delta, 0);
    chk("arst_ts_index", ts_index, 0);
    chk("arst_rd_en", data_word_rd_en, 0);
    step();
    resetn = 1'b1;
    model_clear();
    sb.delete();
    steps(2);
    push_pair(32'h42, 32'h0);
    drain();
    chk("post_rst_orphan", orphan_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
